inst_issue_queue: RTL and testbench
===================================

# inst_issue_queue

In-order instruction buffer between fetch and the dual-issue stage. Accepts up to two fetched instructions per cycle and presents the two oldest to issue slots A and B. Retires zero, one or two entries per cycle according to the hazard unit's issue decisions, and discards all contents on a branch flush. It decouples fetch from issue stalls, so a partially issued pair does not force a refetch.

## Interface
- DEPTH, 8, number of entries; power of two, minimum 4
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  branch flush; discards all entries and this cycle's enqueue
- enq_valid_a  in  1  enqueue the older fetched instruction
- enq_valid_b  in  1  enqueue the younger fetched instruction; legal only with enq_valid_a
- enq_inst_a / enq_inst_b  in  32  instruction words
- enq_pc_a / enq_pc_b  in  32  PCs of the instructions
- enq_ready  out  1  at least two free entries (count <= DEPTH-2)
- slot_valid_a / slot_valid_b  out  1  slot holds the oldest / second-oldest entry
- slot_inst_a / slot_inst_b  out  32  instruction word; NOP 32'h0000_0013 when slot invalid
- slot_pc_a / slot_pc_b  out  32  PC; 0 when slot invalid
- issue_a / issue_b  in  1  hazard unit consumed slot A / slot B this cycle
- count  out  $clog2(DEPTH)+1  current occupancy
- issue_err  out  1  one-cycle pulse on an illegal issue request (registered)

## Operation
- Circular buffer with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Slot A = entry[head]. Slot B = entry[head+1 mod DEPTH].
  - slot_valid_a = (count >= 1).
  - slot_valid_b = (count >= 2).
- Dequeue amount d:
  - d = 2 if issue_a && issue_b && slot_valid_b.
  - d = 1 if issue_a && !issue_b && slot_valid_a.
  - Otherwise d = 0.
  - head advances by d.
- Illegal issue requests:
  - issue_b without issue_a.
  - issue_a with slot A empty.
  - issue_b with slot B empty.
  - Each sets d = 0 and raises issue_err on the next cycle.
- Enqueue amount e:
  - e = 0 unless enq_ready is high.
  - Otherwise e = enq_valid_a + (enq_valid_a && enq_valid_b).
  - Entry A is written at tail and entry B at tail+1. Tail advances by e.
  - enq_valid_b without enq_valid_a is ignored (e = 0) and raises issue_err.
  - Enqueue while enq_ready is low is dropped silently. Fetch must hold its data.
- Count update: count_next = count + e - d.
- enq_ready is based on the current count only, not the count after this cycle's dequeue. This keeps the path combinationally independent of issue_a/issue_b.
- Simultaneous enqueue and dequeue are always allowed. When count <= DEPTH-2, the written entries never overlap entries being read.
- Flush has highest priority after reset:
  - head, tail and count are cleared to 0.
  - Enqueue and dequeue in the same cycle are discarded.
  - issue_err is not raised.
- Reset, including mid-operation:
  - head, tail, count and issue_err are cleared to 0.
  - All slot_valid outputs are 0. Slot outputs show NOP/0.
  - enq_ready is 1.
  - Storage contents are not cleared.

## Timing
- Slot outputs are combinational from head and storage. Zero-latency issue of the current head.
- An enqueued instruction appears in a slot one cycle after its enqueue edge at the earliest.
- Minimum fetch-to-slot latency is 1 cycle.
- count, head and tail update on posedge clk.
- enq_ready and slot_valid_* are decoded from registered count, so they carry no combinational path from any input.
- issue_err is registered: it is high for exactly the one cycle after the offending cycle.

## Structure
- core_types_pkg holds:
  - NOP_INST = 32'h0000_0013.
  - iq_entry_t, a packed struct of {pc[31:0], inst[31:0]}.
- Storage is an array of iq_entry_t of size DEPTH, held inside this module.
- No sub-module. Pointer, count and error logic are local.

## Test plan
- Reset then idle:
  - count=0, enq_ready=1.
  - slot_valid_a/b=0.
  - slot_inst_a=32'h0000_0013, slot_pc_a=0.
- Enqueue pair (pc 0x100/0x104), no issue:
  - Next cycle: count=2, slot_pc_a=0x100, slot_pc_b=0x104.
- Partial issue: with 3 entries (0x100, 0x104, 0x108), assert issue_a only.
  - Next cycle: slot_pc_a=0x104, slot_pc_b=0x108, count=2.
- Fill to DEPTH-1=7:
  - enq_ready=0. A pair enqueue is dropped and count stays 7.
  - Issue both slots: count=5 and enq_ready=1 next cycle.
  - Wrap: pointers cross DEPTH and order is preserved.
- Flush with a simultaneous enqueue and issue_a at count=4:
  - Next cycle: count=0, slot_valid_a=0, issue_err=0.
- Illegal requests:
  - issue_b alone → issue_err=1 for one cycle, count unchanged.
  - issue_a with count=0 → issue_err=1 for one cycle, count unchanged.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared types for the instruction issue queue: NOP encoding and the stored entry layout.
package core_types_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } iq_entry_t;

endpackage

// File: rtl/inst_issue_queue_if.sv
// Fetch/issue-side bundle of the issue queue; master is the fetch+hazard side, slave is the queue.
interface inst_issue_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          enq_valid_a;
  logic          enq_valid_b;
  logic [31:0]   enq_inst_a;
  logic [31:0]   enq_inst_b;
  logic [31:0]   enq_pc_a;
  logic [31:0]   enq_pc_b;
  logic          enq_ready;
  logic          slot_valid_a;
  logic          slot_valid_b;
  logic [31:0]   slot_inst_a;
  logic [31:0]   slot_inst_b;
  logic [31:0]   slot_pc_a;
  logic [31:0]   slot_pc_b;
  logic          issue_a;
  logic          issue_b;
  logic [CW-1:0] count;
  logic          issue_err;

  modport master (
    output flush, enq_valid_a, enq_valid_b, enq_inst_a, enq_inst_b, enq_pc_a, enq_pc_b,
    output issue_a, issue_b,
    input  enq_ready, slot_valid_a, slot_valid_b, slot_inst_a, slot_inst_b,
    input  slot_pc_a, slot_pc_b, count, issue_err
  );

  modport slave (
    input  flush, enq_valid_a, enq_valid_b, enq_inst_a, enq_inst_b, enq_pc_a, enq_pc_b,
    input  issue_a, issue_b,
    output enq_ready, slot_valid_a, slot_valid_b, slot_inst_a, slot_inst_b,
    output slot_pc_a, slot_pc_b, count, issue_err
  );

endinterface

// File: rtl/inst_issue_queue.sv
// In-order dual-enqueue/dual-issue buffer; slots are combinational from head (0-cycle issue, 1-cycle fetch-to-slot).
// enq_ready needs two free entries and depends only on registered count; refused enqueues are dropped.
module inst_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  inst_issue_queue_if.slave  iq
);
  import core_types_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [CW-1:0] count;
  logic [CW-1:0] deq_n;
  logic [CW-1:0] enq_n;
  logic          valid_a;
  logic          valid_b;
  logic          ready;
  logic          issue_bad;
  logic          enq_bad;
  logic          err_q;
  iq_entry_t     entry_a;
  iq_entry_t     entry_b;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);
  assign valid_a = (count != '0);
  assign valid_b = (count >= CW'(2));
  assign ready   = (count <= CW'(DEPTH - 2));
  assign entry_a = mem[head];
  assign entry_b = mem[head_p1];

  assign iq.enq_ready    = ready;
  assign iq.slot_valid_a = valid_a;
  assign iq.slot_valid_b = valid_b;
  assign iq.slot_inst_a  = valid_a ? entry_a.inst : NOP_INST;
  assign iq.slot_pc_a    = valid_a ? entry_a.pc   : 32'h0;
  assign iq.slot_inst_b  = valid_b ? entry_b.inst : NOP_INST;
  assign iq.slot_pc_b    = valid_b ? entry_b.pc   : 32'h0;
  assign iq.count        = count;
  assign iq.issue_err    = err_q;

  always_comb begin
    issue_bad = (iq.issue_b && !iq.issue_a) ||
                (iq.issue_a && !valid_a)    ||
                (iq.issue_b && !valid_b);
    enq_bad   = iq.enq_valid_b && !iq.enq_valid_a;
    deq_n     = '0;
    enq_n     = '0;
    if (!issue_bad && iq.issue_a) begin
      deq_n = iq.issue_b ? CW'(2) : CW'(1);
    end
    // The ready gate uses pre-dequeue count, so a write never lands on a slot being read.
    if (ready && iq.enq_valid_a) begin
      enq_n = iq.enq_valid_b ? CW'(2) : CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else if (iq.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      head  <= head + deq_n[PW-1:0];
      tail  <= tail + enq_n[PW-1:0];
      count <= count + enq_n - deq_n;
      err_q <= issue_bad || enq_bad;
    end
  end

  // Storage carries no reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (!reset && !iq.flush && (enq_n != '0)) begin
      mem[tail] <= '{pc: iq.enq_pc_a, inst: iq.enq_inst_a};
      if (enq_n == CW'(2)) begin
        mem[tail_p1] <= '{pc: iq.enq_pc_b, inst: iq.enq_inst_b};
      end
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed scenarios plus a randomized run against a queue-based reference model of the issue buffer.
module tb_inst_issue_queue;
  import core_types_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  inst_issue_queue_if #(.DEPTH(DEPTH)) iq ();

  inst_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .iq    (iq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  iq_entry_t m_q[$];
  logic      m_err;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic step(input logic fl, input logic va, input logic vb,
                      input logic [31:0] pa, input logic [31:0] pb,
                      input logic ia, input logic ib);
    iq.flush       = fl;
    iq.enq_valid_a = va;
    iq.enq_valid_b = vb;
    iq.enq_pc_a    = pa;
    iq.enq_pc_b    = pb;
    iq.enq_inst_a  = inst_of(pa);
    iq.enq_inst_b  = inst_of(pb);
    iq.issue_a     = ia;
    iq.issue_b     = ib;
    @(posedge clk);
    #1;
    iq.flush       = 1'b0;
    iq.enq_valid_a = 1'b0;
    iq.enq_valid_b = 1'b0;
    iq.issue_a     = 1'b0;
    iq.issue_b     = 1'b0;
  endtask

  // Reference model: a plain FIFO of entries following the spec's enqueue/dequeue rules.
  task automatic model_step(input logic rs, input logic fl, input logic va, input logic vb,
                            input logic [31:0] pa, input logic [31:0] pb,
                            input logic ia, input logic ib);
    int  n;
    logic ibad;
    if (rs || fl) begin
      m_q.delete();
      m_err = 1'b0;
      return;
    end
    n    = m_q.size();
    ibad = (ib && !ia) || (ia && n < 1) || (ib && n < 2);
    m_err = ibad || (vb && !va);
    if (!ibad && ia) begin
      void'(m_q.pop_front());
      if (ib) void'(m_q.pop_front());
    end
    if (n <= DEPTH - 2 && va) begin
      m_q.push_back('{pc: pa, inst: inst_of(pa)});
      if (vb) m_q.push_back('{pc: pb, inst: inst_of(pb)});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    checks += 6;
    if (iq.count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", iq.count); end
    if (iq.enq_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", iq.enq_ready); end
    if (iq.slot_valid_a !== 1'b0 || iq.slot_valid_b !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b%b want 00", iq.slot_valid_a, iq.slot_valid_b);
    end
    if (iq.slot_inst_a !== 32'h0000_0013) begin failures++; $display("FAIL reset_inst_a: got %h want 00000013", iq.slot_inst_a); end
    if (iq.slot_pc_a !== 32'h0) begin failures++; $display("FAIL reset_pc_a: got %h want 0", iq.slot_pc_a); end
    if (iq.issue_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", iq.issue_err); end
  endtask

  task automatic test_enqueue_pair();
    step(0, 1, 1, 32'h100, 32'h104, 0, 0);
    checks += 4;
    if (iq.count !== 4'd2) begin failures++; $display("FAIL pair_count: got %0d want 2", iq.count); end
    if (iq.slot_pc_a !== 32'h100) begin failures++; $display("FAIL pair_pc_a: got %h want 100", iq.slot_pc_a); end
    if (iq.slot_pc_b !== 32'h104) begin failures++; $display("FAIL pair_pc_b: got %h want 104", iq.slot_pc_b); end
    if (iq.slot_inst_a !== inst_of(32'h100)) begin
      failures++; $display("FAIL pair_inst_a: got %h want %h", iq.slot_inst_a, inst_of(32'h100));
    end
  endtask

  task automatic test_partial_issue();
    step(0, 1, 0, 32'h108, 32'h0, 0, 0);
    checks += 1;
    if (iq.count !== 4'd3) begin failures++; $display("FAIL partial_pre_count: got %0d want 3", iq.count); end
    step(0, 0, 0, 0, 0, 1, 0);
    checks += 3;
    if (iq.slot_pc_a !== 32'h104) begin failures++; $display("FAIL partial_pc_a: got %h want 104", iq.slot_pc_a); end
    if (iq.slot_pc_b !== 32'h108) begin failures++; $display("FAIL partial_pc_b: got %h want 108", iq.slot_pc_b); end
    if (iq.count !== 4'd2) begin failures++; $display("FAIL partial_count: got %0d want 2", iq.count); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] order [7];
    order = '{32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C, 32'h120, 32'h124};
    step(0, 1, 1, 32'h10C, 32'h110, 0, 0);
    step(0, 1, 1, 32'h114, 32'h118, 0, 0);
    step(0, 1, 0, 32'h11C, 32'h0, 0, 0);
    checks += 2;
    if (iq.count !== 4'd7) begin failures++; $display("FAIL fill_count: got %0d want 7", iq.count); end
    if (iq.enq_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", iq.enq_ready); end
    step(0, 1, 1, 32'h200, 32'h204, 0, 0);
    checks += 1;
    if (iq.count !== 4'd7) begin failures++; $display("FAIL fill_drop_count: got %0d want 7", iq.count); end
    step(0, 0, 0, 0, 0, 1, 1);
    checks += 3;
    if (iq.count !== 4'd5) begin failures++; $display("FAIL fill_issue2_count: got %0d want 5", iq.count); end
    if (iq.enq_ready !== 1'b1) begin failures++; $display("FAIL fill_issue2_ready: got %b want 1", iq.enq_ready); end
    if (iq.slot_pc_a !== 32'h10C) begin failures++; $display("FAIL fill_issue2_pc_a: got %h want 10c", iq.slot_pc_a); end
    step(0, 1, 1, 32'h120, 32'h124, 0, 0);
    for (int i = 0; i < 7; i += 2) begin
      checks += 1;
      if (iq.slot_pc_a !== order[i]) begin
        failures++; $display("FAIL wrap_pc_a[%0d]: got %h want %h", i, iq.slot_pc_a, order[i]);
      end
      if (i + 1 < 7) begin
        checks += 1;
        if (iq.slot_pc_b !== order[i+1]) begin
          failures++; $display("FAIL wrap_pc_b[%0d]: got %h want %h", i, iq.slot_pc_b, order[i+1]);
        end
        step(0, 0, 0, 0, 0, 1, 1);
      end else begin
        step(0, 0, 0, 0, 0, 1, 0);
      end
    end
    checks += 1;
    if (iq.count !== 4'd0) begin failures++; $display("FAIL wrap_drain_count: got %0d want 0", iq.count); end
  endtask

  task automatic test_flush();
    step(0, 1, 1, 32'h300, 32'h304, 0, 0);
    step(0, 1, 1, 32'h308, 32'h30C, 0, 0);
    checks += 1;
    if (iq.count !== 4'd4) begin failures++; $display("FAIL flush_pre_count: got %0d want 4", iq.count); end
    step(1, 1, 1, 32'h310, 32'h314, 1, 0);
    checks += 4;
    if (iq.count !== 4'd0) begin failures++; $display("FAIL flush_count: got %0d want 0", iq.count); end
    if (iq.slot_valid_a !== 1'b0) begin failures++; $display("FAIL flush_valid_a: got %b want 0", iq.slot_valid_a); end
    if (iq.issue_err !== 1'b0) begin failures++; $display("FAIL flush_err: got %b want 0", iq.issue_err); end
    if (iq.enq_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b want 1", iq.enq_ready); end
    step(1, 0, 0, 0, 0, 0, 1);
    checks += 1;
    if (iq.issue_err !== 1'b0) begin failures++; $display("FAIL flush_illegal_err: got %b want 0", iq.issue_err); end
  endtask

  task automatic test_illegal();
    step(0, 1, 1, 32'h400, 32'h404, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    checks += 2;
    if (iq.issue_err !== 1'b1) begin failures++; $display("FAIL ill_b_alone_err: got %b want 1", iq.issue_err); end
    if (iq.count !== 4'd2) begin failures++; $display("FAIL ill_b_alone_count: got %0d want 2", iq.count); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks += 1;
    if (iq.issue_err !== 1'b0) begin failures++; $display("FAIL ill_b_alone_pulse: got %b want 0", iq.issue_err); end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    checks += 2;
    if (iq.issue_err !== 1'b1) begin failures++; $display("FAIL ill_empty_err: got %b want 1", iq.issue_err); end
    if (iq.count !== 4'd0) begin failures++; $display("FAIL ill_empty_count: got %0d want 0", iq.count); end
    step(0, 0, 0, 0, 0, 0, 0);
    checks += 1;
    if (iq.issue_err !== 1'b0) begin failures++; $display("FAIL ill_empty_pulse: got %b want 0", iq.issue_err); end
    step(0, 0, 1, 32'h0, 32'h500, 0, 0);
    checks += 2;
    if (iq.issue_err !== 1'b1) begin failures++; $display("FAIL ill_enq_b_err: got %b want 1", iq.issue_err); end
    if (iq.count !== 4'd0) begin failures++; $display("FAIL ill_enq_b_count: got %0d want 0", iq.count); end
  endtask

  task automatic test_random();
    logic [31:0] pc_gen;
    logic        rs, fl, va, vb, ia, ib;
    logic [3:0]  e_cnt;
    logic [31:0] e_pa, e_pb, e_ia, e_ib;
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    pc_gen = 32'h1000;
    for (int cyc = 0; cyc < 600; cyc++) begin
      e_cnt = 4'(m_q.size());
      e_pa  = (m_q.size() >= 1) ? m_q[0].pc   : 32'h0;
      e_ia  = (m_q.size() >= 1) ? m_q[0].inst : NOP_INST;
      e_pb  = (m_q.size() >= 2) ? m_q[1].pc   : 32'h0;
      e_ib  = (m_q.size() >= 2) ? m_q[1].inst : NOP_INST;
      checks += 9;
      if (iq.count !== e_cnt) begin failures++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, iq.count, e_cnt); end
      if (iq.enq_ready !== (m_q.size() <= DEPTH - 2)) begin
        failures++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, iq.enq_ready, m_q.size() <= DEPTH - 2);
      end
      if (iq.slot_valid_a !== (m_q.size() >= 1)) begin failures++; $display("FAIL rnd_valid_a@%0d: got %b", cyc, iq.slot_valid_a); end
      if (iq.slot_valid_b !== (m_q.size() >= 2)) begin failures++; $display("FAIL rnd_valid_b@%0d: got %b", cyc, iq.slot_valid_b); end
      if (iq.slot_pc_a !== e_pa) begin failures++; $display("FAIL rnd_pc_a@%0d: got %h want %h", cyc, iq.slot_pc_a, e_pa); end
      if (iq.slot_inst_a !== e_ia) begin failures++; $display("FAIL rnd_inst_a@%0d: got %h want %h", cyc, iq.slot_inst_a, e_ia); end
      if (iq.slot_pc_b !== e_pb) begin failures++; $display("FAIL rnd_pc_b@%0d: got %h want %h", cyc, iq.slot_pc_b, e_pb); end
      if (iq.slot_inst_b !== e_ib) begin failures++; $display("FAIL rnd_inst_b@%0d: got %h want %h", cyc, iq.slot_inst_b, e_ib); end
      if (iq.issue_err !== m_err) begin failures++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, iq.issue_err, m_err); end
      rs = ($urandom_range(0, 79) == 0);
      fl = ($urandom_range(0, 31) == 0);
      va = ($urandom_range(0, 3) != 0);
      vb = va ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      ia = ($urandom_range(0, 2) != 0);
      ib = ia ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      reset = rs;
      step(fl, va, vb, pc_gen, pc_gen + 32'd4, ia, ib);
      reset = 1'b0;
      model_step(rs, fl, va, vb, pc_gen, pc_gen + 32'd4, ia, ib);
      pc_gen = pc_gen + 32'd8;
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    m_err          = 1'b0;
    reset          = 1'b1;
    iq.flush       = 1'b0;
    iq.enq_valid_a = 1'b0;
    iq.enq_valid_b = 1'b0;
    iq.enq_pc_a    = '0;
    iq.enq_pc_b    = '0;
    iq.enq_inst_a  = '0;
    iq.enq_inst_b  = '0;
    iq.issue_a     = 1'b0;
    iq.issue_b     = 1'b0;
    #1;
    test_reset();
    test_enqueue_pair();
    test_partial_issue();
    test_fill_wrap();
    test_flush();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
